// File: rtl/uart_pkg.sv
// Shared definitions for the UART TX arbiter slice.
//   UART_DATA_W : byte width on every requester lane and on the TX side
//   arb_state_t : arbiter FSM states
package uart_pkg;

  localparam int unsigned UART_DATA_W = 8;

  typedef enum logic {
    ARB_IDLE   = 1'b0,
    ARB_STREAM = 1'b1
  } arb_state_t;

endpackage

// File: rtl/uart_tx_arbiter_rr_picker.sv
// rr_picker: combinational round-robin first-one search.
// Starting at index ptr and wrapping modulo N_REQ, selects the first
// requester whose valid bit is set.
//   valid : per-requester request bits
//   ptr   : index with highest priority this search
//   pick  : one-hot selected requester (all zero when none valid)
//   idx   : binary index of the selected requester
//   found : at least one requester was valid
module rr_picker #(
  parameter int unsigned N_REQ = 2,
  localparam int unsigned IDX_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] valid,
  input  logic [IDX_W-1:0] ptr,
  output logic [N_REQ-1:0] pick,
  output logic [IDX_W-1:0] idx,
  output logic             found
);

  // One spare bit so ptr + k can be wrapped without overflowing.
  logic [IDX_W:0] r;

  always_comb begin
    pick  = '0;
    idx   = '0;
    found = 1'b0;
    r     = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      r = {1'b0, ptr} + (IDX_W+1)'(k);
      if (r >= (IDX_W+1)'(N_REQ)) r = r - (IDX_W+1)'(N_REQ);
      if (!found && valid[r[IDX_W-1:0]]) begin
        found              = 1'b1;
        pick[r[IDX_W-1:0]] = 1'b1;
        idx                = r[IDX_W-1:0];
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: shares one UART TX serializer among N_REQ byte streams.
// A grant is held for a packet (until req_last) or MAX_BURST bytes,
// whichever comes first; releases pass priority round-robin and always
// cost one IDLE cycle.
// Optional feature macro: UART_ARB_TIMEOUT_EN -- revokes a grant after
// TIMEOUT_CYC consecutive STREAM cycles without a transfer.
// Ports:
//   clk, rst_n  : clock, async active-low reset
//   req_data    : N_REQ bytes, requester i on bits [8i+7:8i]
//   req_valid   : requester has a byte
//   req_last    : byte ends its packet
//   req_ready   : byte accepted this cycle (owner only)
//   tx_data     : byte to the serializer
//   tx_valid    : byte offered to the serializer
//   tx_ready    : serializer accepts the byte
//   grant       : one-hot current owner, zero when idle
//   busy        : a grant is active
//   timeout_evt : one-cycle pulse when a grant is revoked by timeout
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int unsigned N_REQ       = 2,
  parameter int unsigned MAX_BURST   = 16,
  parameter int unsigned TIMEOUT_CYC = 1024
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [N_REQ*UART_DATA_W-1:0] req_data,
  input  logic [N_REQ-1:0]             req_valid,
  input  logic [N_REQ-1:0]             req_last,
  output logic [N_REQ-1:0]             req_ready,
  output logic [UART_DATA_W-1:0]       tx_data,
  output logic                         tx_valid,
  input  logic                         tx_ready,
  output logic [N_REQ-1:0]             grant,
  output logic                         busy,
  output logic                         timeout_evt
);

  localparam int unsigned IDX_W = $clog2(N_REQ);

  arb_state_t       state;
  logic [IDX_W-1:0] owner;
  logic [IDX_W-1:0] rr_ptr;
  logic [7:0]       burst_cnt;

  logic [N_REQ-1:0] pick;
  logic [IDX_W-1:0] pick_idx;
  logic             pick_found;

  logic             owner_last;
  logic             xfer;
  logic             burst_done;
  logic             stall_hit;
  logic [IDX_W-1:0] next_ptr;

  logic [UART_DATA_W-1:0] lane [N_REQ];

  rr_picker #(.N_REQ(N_REQ)) u_picker (
    .valid (req_valid),
    .ptr   (rr_ptr),
    .pick  (pick),
    .idx   (pick_idx),
    .found (pick_found)
  );

  always_comb begin
    for (int unsigned i = 0; i < N_REQ; i++) begin
      lane[i] = req_data[i*UART_DATA_W +: UART_DATA_W];
    end
  end

  // Datapath mux: ready depends only on state, owner and tx_ready,
  // never on req_valid.
  always_comb begin
    tx_data    = '0;
    tx_valid   = 1'b0;
    req_ready  = '0;
    owner_last = 1'b0;
    if (state == ARB_STREAM) begin
      tx_data          = lane[owner];
      tx_valid         = req_valid[owner];
      req_ready[owner] = tx_ready;
      owner_last       = req_last[owner];
    end
  end

  assign xfer       = tx_valid & tx_ready;
  // Equivalent to "count after increment == MAX_BURST".
  assign burst_done = owner_last | (burst_cnt == 8'(MAX_BURST - 1));
  assign next_ptr   = (owner == IDX_W'(N_REQ - 1)) ? '0 : owner + 1'b1;
  assign busy       = (state == ARB_STREAM);

`ifdef UART_ARB_TIMEOUT_EN
  localparam int unsigned TOUT_W = $clog2(TIMEOUT_CYC + 1);

  logic [TOUT_W-1:0] stall_cnt;

  assign stall_hit = (state == ARB_STREAM) && !xfer &&
                     (stall_cnt == TOUT_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt   <= '0;
      timeout_evt <= 1'b0;
    end else begin
      timeout_evt <= stall_hit;
      if (state != ARB_STREAM || xfer || stall_hit) stall_cnt <= '0;
      else                                         stall_cnt <= stall_cnt + 1'b1;
    end
  end
`else
  assign stall_hit   = 1'b0;
  assign timeout_evt = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ARB_IDLE;
      owner     <= '0;
      rr_ptr    <= '0;
      burst_cnt <= '0;
      grant     <= '0;
    end else begin
      case (state)
        ARB_IDLE: begin
          if (pick_found) begin
            state     <= ARB_STREAM;
            owner     <= pick_idx;
            grant     <= pick;
            burst_cnt <= '0;
          end
        end
        ARB_STREAM: begin
          if (xfer) burst_cnt <= burst_cnt + 8'd1;
          // last and burst cap coinciding still yields a single release
          if ((xfer && burst_done) || stall_hit) begin
            state  <= ARB_IDLE;
            grant  <= '0;
            rr_ptr <= next_ptr;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
`timescale 1ns/1ps
module tb_uart_tx_arbiter;

  localparam int N  = 2;
  localparam int MB = 4;
  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] req_data;
  logic [1:0]  req_valid, req_last, req_ready, grant;
  logic [7:0]  tx_data;
  logic        tx_valid, tx_ready, busy, timeout_evt;

  uart_tx_arbiter #(.N_REQ(N), .MAX_BURST(MB), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_data(req_data), .req_valid(req_valid), .req_last(req_last),
    .req_ready(req_ready),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .grant(grant), .busy(busy), .timeout_evt(timeout_evt)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic [7:0] d; logic last; } ent_t;

  ent_t       q0[$];
  ent_t       q1[$];
  logic [7:0] txlog[$];
  bit   [1:0] en;
  int         tr_mode;          // 0 ready low, 1 ready high, 2 random
  int         total = 0;
  int         bad = 0;
  bit         timeout_on;

  // Reference model: who owns the serializer, where priority starts,
  // bytes moved in this grant, stalled cycles in this grant.
  int m_owner, m_ptr, m_cnt, m_stall;
  bit m_evt;

  function automatic bit has(int i);
    return (i == 0) ? (q0.size() != 0) : (q1.size() != 0);
  endfunction

  function automatic ent_t head(int i);
    ent_t e;
    e = '0;
    if (i == 0 && q0.size() != 0) e = q0[0];
    if (i == 1 && q1.size() != 0) e = q1[0];
    return e;
  endfunction

  task automatic pop(int i);
    if (i == 0) void'(q0.pop_front());
    else        void'(q1.pop_front());
  endtask

  task automatic push_byte(int i, logic [7:0] d, logic last);
    ent_t e;
    e.d = d;
    e.last = last;
    if (i == 0) q0.push_back(e);
    else        q1.push_back(e);
  endtask

  task automatic push_pkt(int i, int len, bit with_last);
    for (int j = 0; j < len; j++)
      push_byte(i, 8'($urandom), with_last && (j == len - 1));
  endtask

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_owner = -1; m_ptr = 0; m_cnt = 0; m_stall = 0; m_evt = 0;
  endtask

  task automatic drive();
    ent_t e;
    for (int i = 0; i < N; i++) begin
      e = head(i);
      req_valid[i]        = en[i] && has(i);
      req_data[i*8 +: 8]  = e.d;
      req_last[i]         = e.last;
    end
    case (tr_mode)
      0:       tx_ready = 1'b0;
      1:       tx_ready = 1'b1;
      default: tx_ready = 1'($urandom_range(0, 1));
    endcase
  endtask

  task automatic step();
    logic [1:0] eg, er;
    logic       ev;
    logic [7:0] ed;
    bit         xf;
    ent_t       e;
    int         r;
    @(negedge clk);
    drive();
    #1;
    eg = '0; er = '0; ev = 1'b0; ed = '0;
    if (m_owner >= 0) begin
      eg = 2'(1 << m_owner);
      ev = en[m_owner] && has(m_owner);
      if (tx_ready) er = 2'(1 << m_owner);
      e  = head(m_owner);
      ed = e.d;
    end
    check("grant",       grant,       eg);
    check("busy",        busy,        m_owner >= 0);
    check("tx_valid",    tx_valid,    ev);
    check("req_ready",   req_ready,   er);
    check("timeout_evt", timeout_evt, m_evt);
    if (ev) check("tx_data", tx_data, ed);
    if (tx_valid && tx_ready) txlog.push_back(tx_data);
    xf = ev && tx_ready;
    @(posedge clk);
    m_evt = 0;
    if (m_owner < 0) begin
      for (int k = 0; k < N; k++) begin
        r = (m_ptr + k) % N;
        if (m_owner < 0 && en[r] && has(r)) m_owner = r;
      end
      m_cnt = 0;
      m_stall = 0;
    end else if (xf) begin
      e = head(m_owner);
      pop(m_owner);
      m_cnt++;
      m_stall = 0;
      if (e.last || m_cnt == MB) begin
        m_ptr = (m_owner + 1) % N;
        m_owner = -1;
      end
    end else begin
      m_stall++;
      if (timeout_on && m_stall == TO) begin
        m_ptr = (m_owner + 1) % N;
        m_owner = -1;
        m_evt = 1;
      end
    end
  endtask

  task automatic drain(int maxc);
    int n;
    n = 0;
    while ((has(0) || has(1) || m_owner >= 0) && n < maxc) begin
      step();
      n++;
    end
    if (n >= maxc) check("drain_bound", q0.size() + q1.size(), 0);
    step();
  endtask

  // Reset asserted between clock edges, checked before the next edge.
  task automatic apply_reset();
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_grant",     grant,       0);
    check("rst_busy",      busy,        0);
    check("rst_tx_valid",  tx_valid,    0);
    check("rst_req_ready", req_ready,   0);
    check("rst_tout",      timeout_evt, 0);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    model_reset();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    timeout_on = 1'b0;
`ifdef UART_ARB_TIMEOUT_EN
    timeout_on = 1'b1;
`endif
    model_reset();
    en = 2'b11; tr_mode = 1;
    req_data = 16'h4241; req_valid = 2'b11; req_last = 2'b00; tx_ready = 1'b1;

    // Reset state with requests already pending
    #12;
    check("por_grant",     grant,       0);
    check("por_busy",      busy,        0);
    check("por_tx_valid",  tx_valid,    0);
    check("por_req_ready", req_ready,   0);
    check("por_tout",      timeout_evt, 0);
    @(posedge clk);
    #2;
    rst_n = 1'b1;

    // Single requester, three-byte packet
    txlog.delete();
    push_byte(0, 8'h41, 1'b0);
    push_byte(0, 8'h42, 1'b0);
    push_byte(0, 8'h43, 1'b1);
    drain(50);
    check("single_len", txlog.size(), 3);
    if (txlog.size() == 3) begin
      check("single_b0", txlog[0], 8'h41);
      check("single_b1", txlog[1], 8'h42);
      check("single_b2", txlog[2], 8'h43);
    end

    // Contention from reset: req0, bubble, req1, bubble, req0
    apply_reset();
    txlog.delete();
    push_pkt(0, 2, 1); push_pkt(0, 2, 1); push_pkt(1, 2, 1);
    drain(100);
    check("contend_len", txlog.size(), 6);

    // Burst cap: req1 streams 10 bytes, req0 arrives one cycle later
    apply_reset();
    push_pkt(1, 10, 1);
    step();
    push_pkt(0, 3, 1);
    drain(200);

    // Backpressure mid-packet
    push_pkt(0, 5, 1);
    step(); step(); step();
    tr_mode = 0;
    for (int i = 0; i < 20; i++) step();
    tr_mode = 1;
    drain(100);

    // Owner drops valid mid-packet for a long time
    apply_reset();
    push_pkt(0, 4, 1); push_pkt(1, 2, 1);
    n = 0;
    while (m_cnt < 2 && n < 50) begin step(); n++; end
    check("drop_reach", m_cnt, 2);
    en[0] = 1'b0;
    for (int i = 0; i < 110; i++) step();
    if (!timeout_on) check("drop_held", grant, 2'b01);
    en = 2'b11;
    drain(200);

    // Reset after byte 2 of 5; requester 0 first afterwards
    apply_reset();
    push_pkt(0, 5, 1); push_pkt(1, 3, 1);
    n = 0;
    while (!(m_owner == 0 && m_cnt == 2) && n < 50) begin step(); n++; end
    check("mid_reach", m_cnt, 2);
    apply_reset();
    step();
    step();
    check("post_rst_owner", grant, 2'b01);
    drain(200);

    // Randomized traffic
    tr_mode = 2;
    for (int i = 0; i < 400; i++) begin
      if (q0.size() < 3) push_pkt(0, $urandom_range(1, 6), $urandom_range(0, 3) != 0);
      if (q1.size() < 3) push_pkt(1, $urandom_range(1, 6), $urandom_range(0, 3) != 0);
      if ($urandom_range(0, 7) == 0) en[0] = ~en[0];
      if ($urandom_range(0, 7) == 0) en[1] = ~en[1];
      step();
    end
    en = 2'b11;
    tr_mode = 1;
    if (q0.size() != 0) q0[q0.size()-1].last = 1'b1;
    if (q1.size() != 0) q1[q1.size()-1].last = 1'b1;
    drain(2000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 SHALL have parameter N_REQ, default 2, number of byte-stream requesters sharing the UART TX serializer (range 2..8).
REQ-002 SHALL have parameter MAX_BURST, default 16, maximum bytes per grant (range 1..255).
REQ-003 SHALL have parameter TIMEOUT_CYC, default 1024, idle cycles before a stalled grant is revoked (used only with UART_ARB_TIMEOUT_EN).
REQ-004 SHALL have ports:
  - clk  in  1  single clock, rising edge.
  - rst_n  in  1  reset; asynchronous assertion, active-low.
  - req_data  in  N_REQ x 8  byte from each requester.
  - req_valid  in  N_REQ  requester has a byte.
  - req_last  in  N_REQ  byte is the last of its packet.
  - req_ready  out  N_REQ  byte accepted this cycle.
  - tx_data  out  8  byte to the TX serializer.
  - tx_valid  out  1  byte offered to the serializer.
  - tx_ready  in  1  serializer accepts the byte.
  - grant  out  N_REQ  one-hot current owner, all zero when idle.
  - busy  out  1  a grant is active.
  - timeout_evt  out  1  one-cycle pulse when a grant is revoked by timeout.

Function
REQ-005 SHALL implement an FSM with exactly two states: IDLE and STREAM.
REQ-006 In IDLE, when any req_valid is high, SHALL pick the first requester with valid high, searching round-robin from rr_ptr, and enter STREAM next cycle with grant registered.
REQ-007 In IDLE, tx_valid SHALL be 0, req_ready SHALL be all 0, and grant SHALL be all 0.
REQ-008 In STREAM with owner g, tx_data SHALL equal req_data[g], tx_valid SHALL equal req_valid[g], and req_ready[g] SHALL equal tx_ready; all other req_ready bits SHALL be 0.
REQ-009 A transfer SHALL occur on any cycle where tx_valid and tx_ready are both high; there is no combinational path from req_valid to req_ready.
REQ-010 SHALL keep an 8-bit burst counter, cleared on grant and incremented on each transfer.
REQ-011 SHALL release the grant (STREAM->IDLE) on the cycle after a transfer that has req_last[g] high, or whose post-increment count equals MAX_BURST.
REQ-012 On release, rr_ptr SHALL become (g+1) mod N_REQ, giving g lowest priority; each release SHALL cost exactly one IDLE bubble cycle.
REQ-013 If req_last and the MAX_BURST condition coincide, SHALL perform one release only.
REQ-014 If req_valid[g] drops mid-packet, SHALL hold the grant; tx_valid follows req_valid[g].
REQ-015 Requests from non-owners SHALL be ignored until the next IDLE; no requester is starved, with worst-case wait (N_REQ-1) x (MAX_BURST+1) transfers plus stalls.
REQ-016 busy SHALL equal (state == STREAM).

Reset
REQ-017 On rst_n low, SHALL set state=IDLE, rr_ptr=0, burst counter=0, timeout counter=0, grant=0, busy=0, and timeout_evt=0; tx_valid and req_ready SHALL read 0.
REQ-018 Reset asserted mid-STREAM SHALL drop the grant immediately with no byte lost or duplicated on the TX side beyond the reset cycle; after reset, requester 0 has first priority.

Configuration
REQ-019 SHALL support macro UART_ARB_TIMEOUT_EN. When it is defined, a counter SHALL count STREAM cycles with no transfer and SHALL clear on each transfer.
REQ-020 With UART_ARB_TIMEOUT_EN defined, when that counter reaches TIMEOUT_CYC, SHALL release the grant as in REQ-012 and pulse timeout_evt for one cycle.
REQ-021 Without UART_ARB_TIMEOUT_EN, the grant SHALL be held indefinitely, timeout_evt SHALL be tied to 0, and no counter logic SHALL be present.

Structure
REQ-022 A shared package uart_pkg SHALL hold the FSM state enum (ARB_IDLE, ARB_STREAM) and the byte width constant UART_DATA_W=8.
REQ-023 One sub-module, rr_picker, SHALL be used: combinational round-robin first-one search taking req_valid and rr_ptr and producing a one-hot pick and its index. All registers SHALL live in uart_tx_arbiter.

Verification
REQ-024 Bench SHALL cover:
  - Single requester: req0 sends 3 bytes 0x41,0x42,0x43 with last on 0x43, tx_ready always 1 -> tx_data sequence 41,42,43; grant=01 for 3 cycles, then IDLE.
  - Contention: req0 and req1 both valid with 2-byte packets from reset -> req0 served first, then 1 bubble, then req1, then req0 again if still valid.
  - Burst cap: MAX_BURST=4, req1 sends 10 bytes with no last, req0 waiting -> req1 gets 4 bytes, req0 gets its packet, then req1 resumes.
  - Backpressure: tx_ready low for 20 cycles mid-packet -> tx_data stable, req_ready 0, no byte lost, grant held.
  - Timeout (macro on, TIMEOUT_CYC=8): owner drops valid mid-packet -> timeout_evt pulses after 8 idle cycles and the next requester is granted; macro off -> grant held 100+ cycles.
  - Reset mid-STREAM after byte 2 of 5 -> grant=0 next cycle, and after release requester 0 has priority.
